// File: rtl/control_multiciclo.sv
// Multicycle RISC-V control unit: Moore FSM sequencing fetch/decode/execute,
// with combinational ALU and immediate decoders and PC-write gating.
module control_multiciclo (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       MemW,
    output logic       RegW,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECUTEI = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_RTYP = 7'b0110011;
    localparam logic [6:0] OP_ITYP = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    state_t state_reg;
    state_t state_next;

    // Moore control values before reset gating
    logic       pc_update;
    logic       branch;
    logic [1:0] alu_op;
    logic       ir_write_m;
    logic       mem_w_m;
    logic       reg_w_m;
    logic       adr_src_m;
    logic [1:0] result_src_m;
    logic [1:0] alu_src_a_m;
    logic [1:0] alu_src_b_m;
    logic [2:0] alu_control_m;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // op is only consulted in DECODE and MEMADR
    always_comb begin
        state_next = S_FETCH;
        case (state_reg)
            S_FETCH:    state_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYP:      state_next = S_EXECUTER;
                    OP_ITYP:      state_next = S_EXECUTEI;
                    OP_JAL:       state_next = S_JAL;
                    OP_BEQ:       state_next = S_BEQ;
                    default:      state_next = S_FETCH;
                endcase
            end
            S_MEMADR:   state_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_next = S_MEMWB;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: state_next = S_FETCH;
            S_EXECUTER: state_next = S_ALUWB;
            S_EXECUTEI: state_next = S_ALUWB;
            S_JAL:      state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_BEQ:      state_next = S_FETCH;
            default:    state_next = S_FETCH;
        endcase
    end

    always_comb begin
        pc_update    = 1'b0;
        branch       = 1'b0;
        alu_op       = 2'b00;
        ir_write_m   = 1'b0;
        mem_w_m      = 1'b0;
        reg_w_m      = 1'b0;
        adr_src_m    = 1'b0;
        result_src_m = 2'b00;
        alu_src_a_m  = 2'b00;
        alu_src_b_m  = 2'b00;
        case (state_reg)
            S_FETCH: begin
                ir_write_m   = 1'b1;
                pc_update    = 1'b1;
                alu_src_b_m  = 2'b10;
                result_src_m = 2'b10;
            end
            S_DECODE: begin
                alu_src_a_m = 2'b01;
                alu_src_b_m = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a_m = 2'b10;
                alu_src_b_m = 2'b01;
            end
            S_MEMREAD:  adr_src_m = 1'b1;
            S_MEMWB: begin
                result_src_m = 2'b01;
                reg_w_m      = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src_m = 1'b1;
                mem_w_m   = 1'b1;
            end
            S_EXECUTER: begin
                alu_src_a_m = 2'b10;
                alu_op      = 2'b10;
            end
            S_EXECUTEI: begin
                alu_src_a_m = 2'b10;
                alu_src_b_m = 2'b01;
                alu_op      = 2'b10;
            end
            S_ALUWB:    reg_w_m = 1'b1;
            S_JAL: begin
                alu_src_a_m = 2'b01;
                alu_src_b_m = 2'b10;
                pc_update   = 1'b1;
            end
            S_BEQ: begin
                alu_src_a_m = 2'b10;
                alu_op      = 2'b01;
                branch      = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        alu_control_m = 3'b000;
        case (alu_op)
            2'b01: alu_control_m = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  alu_control_m = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  alu_control_m = 3'b101;
                    3'b110:  alu_control_m = 3'b011;
                    3'b111:  alu_control_m = 3'b010;
                    default: alu_control_m = 3'b000;
                endcase
            end
            default: alu_control_m = 3'b000;
        endcase
    end

    always_comb begin
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    // While reset is held the outputs look like FETCH with every write enable off
    always_comb begin
        if (!rst_n) begin
            PCWrite    = 1'b0;
            IRWrite    = 1'b0;
            MemW       = 1'b0;
            RegW       = 1'b0;
            AdrSrc     = 1'b0;
            ResultSrc  = 2'b10;
            ALUSrcA    = 2'b00;
            ALUSrcB    = 2'b10;
            ALUControl = 3'b000;
            state      = S_FETCH;
        end else begin
            PCWrite    = pc_update | (branch & zero);
            IRWrite    = ir_write_m;
            MemW       = mem_w_m;
            RegW       = reg_w_m;
            AdrSrc     = adr_src_m;
            ResultSrc  = result_src_m;
            ALUSrcA    = alu_src_a_m;
            ALUSrcB    = alu_src_b_m;
            ALUControl = alu_control_m;
            state      = state_reg;
        end
    end

endmodule

// File: tb/tb_control_multiciclo.sv
// Directed bench for control_multiciclo: walks each instruction class through
// its state sequence and checks the control outputs along the way.
module tb_control_multiciclo;

    logic       clk;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       PCWrite, IRWrite, MemW, RegW, AdrSrc;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] state;

    int checks_cnt;
    int fail_cnt;

    control_multiciclo dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
        .PCWrite    (PCWrite),
        .IRWrite    (IRWrite),
        .MemW       (MemW),
        .RegW       (RegW),
        .AdrSrc     (AdrSrc),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // advance one edge and check the resulting state
    task automatic step_state(input string tag, input logic [3:0] exp);
        tick();
        check(tag, {28'd0, state}, {28'd0, exp});
    endtask

    initial begin
        checks_cnt = 0;
        fail_cnt   = 0;
        rst_n      = 1'b0;
        op         = 7'b0110011;
        funct3     = 3'b000;
        funct7b5   = 1'b1;
        zero       = 1'b0;

        tick();
        tick();
        check("rst_pcwrite",   {31'd0, PCWrite}, 32'd0);
        check("rst_irwrite",   {31'd0, IRWrite}, 32'd0);
        check("rst_regw",      {31'd0, RegW},    32'd0);
        check("rst_memw",      {31'd0, MemW},    32'd0);
        check("rst_alusrcb",   {30'd0, ALUSrcB}, 32'd2);
        check("rst_resultsrc", {30'd0, ResultSrc}, 32'd2);
        rst_n = 1'b1;
        #1;
        check("fetch_state",   {28'd0, state},   32'd0);
        check("fetch_irwrite", {31'd0, IRWrite}, 32'd1);
        check("fetch_pcwrite", {31'd0, PCWrite}, 32'd1);

        // R-type sub; op is scrambled in EXECUTER and must not matter
        step_state("r_decode", 4'd1);
        check("r_dec_srca", {30'd0, ALUSrcA}, 32'd1);
        check("r_dec_srcb", {30'd0, ALUSrcB}, 32'd1);
        check("r_dec_regw", {31'd0, RegW}, 32'd0);
        step_state("r_exec", 4'd6);
        check("r_exec_aluctl", {29'd0, ALUControl}, 32'd1);
        check("r_exec_regw", {31'd0, RegW}, 32'd0);
        op = 7'b0000011;
        step_state("r_aluwb", 4'd7);
        check("r_aluwb_regw", {31'd0, RegW}, 32'd1);
        step_state("r_fetch", 4'd0);
        check("r_fetch_regw", {31'd0, RegW}, 32'd0);

        // lw
        op = 7'b0000011;
        #1;
        check("lw_immsrc", {30'd0, ImmSrc}, 32'd0);
        step_state("lw_decode", 4'd1);
        step_state("lw_memadr", 4'd2);
        check("lw_adr_srca", {30'd0, ALUSrcA}, 32'd2);
        step_state("lw_memread", 4'd3);
        check("lw_memread_adrsrc", {31'd0, AdrSrc}, 32'd1);
        check("lw_memread_regw", {31'd0, RegW}, 32'd0);
        step_state("lw_memwb", 4'd4);
        check("lw_memwb_resultsrc", {30'd0, ResultSrc}, 32'd1);
        check("lw_memwb_regw", {31'd0, RegW}, 32'd1);
        step_state("lw_fetch", 4'd0);

        // sw
        op = 7'b0100011;
        #1;
        check("sw_immsrc", {30'd0, ImmSrc}, 32'd1);
        step_state("sw_decode", 4'd1);
        step_state("sw_memadr", 4'd2);
        step_state("sw_memwrite", 4'd5);
        check("sw_memw", {31'd0, MemW}, 32'd1);
        check("sw_adrsrc", {31'd0, AdrSrc}, 32'd1);
        check("sw_regw", {31'd0, RegW}, 32'd0);
        step_state("sw_fetch", 4'd0);
        check("sw_fetch_memw", {31'd0, MemW}, 32'd0);

        // beq taken then not taken
        for (int k = 0; k < 2; k++) begin
            op   = 7'b1100011;
            zero = (k == 0);
            step_state("beq_decode", 4'd1);
            check("beq_immsrc", {30'd0, ImmSrc}, 32'd2);
            step_state("beq_state", 4'd10);
            check("beq_pcwrite", {31'd0, PCWrite}, (k == 0) ? 32'd1 : 32'd0);
            check("beq_aluctl", {29'd0, ALUControl}, 32'd1);
            step_state("beq_fetch", 4'd0);
        end
        zero = 1'b0;

        // I-type or: op[5]=0 so funct7b5 never selects subtract
        op       = 7'b0010011;
        funct3   = 3'b110;
        step_state("i_decode", 4'd1);
        step_state("i_exec", 4'd8);
        check("i_or_aluctl", {29'd0, ALUControl}, 32'd3);
        check("i_srcb", {30'd0, ALUSrcB}, 32'd1);
        funct3 = 3'b000;
        #1;
        check("i_add_aluctl", {29'd0, ALUControl}, 32'd0);
        step_state("i_aluwb", 4'd7);
        check("i_aluwb_regw", {31'd0, RegW}, 32'd1);
        step_state("i_fetch", 4'd0);

        // jal
        op = 7'b1101111;
        step_state("jal_decode", 4'd1);
        check("jal_immsrc", {30'd0, ImmSrc}, 32'd3);
        step_state("jal_state", 4'd9);
        check("jal_pcwrite", {31'd0, PCWrite}, 32'd1);
        check("jal_srcb", {30'd0, ALUSrcB}, 32'd2);
        check("jal_regw", {31'd0, RegW}, 32'd0);
        step_state("jal_aluwb", 4'd7);
        check("jal_aluwb_regw", {31'd0, RegW}, 32'd1);
        step_state("jal_fetch", 4'd0);

        // illegal opcode skipped
        op = 7'b1111111;
        step_state("ill_decode", 4'd1);
        check("ill_regw", {31'd0, RegW}, 32'd0);
        check("ill_memw", {31'd0, MemW}, 32'd0);
        check("ill_pcwrite", {31'd0, PCWrite}, 32'd0);
        step_state("ill_fetch", 4'd0);

        // lw aborted by reset while in MEMWB
        op = 7'b0000011;
        step_state("ab_decode", 4'd1);
        step_state("ab_memadr", 4'd2);
        step_state("ab_memread", 4'd3);
        step_state("ab_memwb", 4'd4);
        rst_n = 1'b0;
        #1;
        check("ab_rst_regw", {31'd0, RegW}, 32'd0);
        check("ab_rst_pcwrite", {31'd0, PCWrite}, 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check("ab_after_state", {28'd0, state}, 32'd0);
        check("ab_after_irwrite", {31'd0, IRWrite}, 32'd1);
        check("ab_after_regw", {31'd0, RegW}, 32'd0);
        step_state("ab_re_decode", 4'd1);
        check("ab_re_decode_regw", {31'd0, RegW}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
